matmul_result_streamer: RTL and testbench
=========================================

Name: matmul_result_streamer

Overview:
- Drain side of the matrix-multiply datapath.
- Captures the flat packed result vector produced by the matmul unit on a load pulse, then serialises it one accumulator element per handshake.
- Output is a valid/ready stream, row-major, element (0,0) first, toward the writeback buffer or host interface.
- Frees the matmul unit to start the next product while the previous result drains.

Parameters:
- ACC_WIDTH, 16, width of one result element.
- ROW_LEN, 3, rows of the result matrix.
- COL_LEN, 3, columns of the result matrix.
- NUM_ELEMS, ROW_LEN*COL_LEN, derived element count; do not override.
- IDX_W, 4, width of the element/row/col index outputs; must satisfy 2^IDX_W > NUM_ELEMS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- load  in  1  capture result_in; honoured only when busy=0.
- result_in  in  NUM_ELEMS*ACC_WIDTH  packed result. Element e=m*COL_LEN+n occupies bits [(NUM_ELEMS-e)*ACC_WIDTH-1 -: ACC_WIDTH], so (0,0) sits in the MSBs.
- busy  out  1  high while a captured matrix is still draining.
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  downstream accepts the current element.
- out_data  out  ACC_WIDTH  current element value.
- out_row  out  IDX_W  row index m of the current element.
- out_col  out  IDX_W  column index n of the current element.
- out_last  out  1  current element is (ROW_LEN-1, COL_LEN-1).
- done  out  1  one-cycle pulse after the last element is accepted.
- overrun  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clock edge), all outputs and state:
  - busy=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, done=0, overrun=0.
  - Capture register cleared; FSM to IDLE.
  - Reset mid-stream abandons the matrix; nothing further is emitted.
- FSM states: IDLE, STREAM.
- IDLE:
  - load=1 at edge T copies result_in into the capture register and zeroes the element counter.
  - Moves to STREAM; at T+1, out_valid=1 with element 0 (out_row=0, out_col=0).
  - Load-to-first-valid latency is exactly 1 cycle.
- STREAM:
  - Handshake occurs on a clock edge with out_valid=1 and out_ready=1. It advances the counter; col wraps COL_LEN-1 -> 0 and increments row.
  - Next element is presented in the following cycle with out_valid kept at 1, giving 1 element/cycle under continuous ready.
  - While out_valid=1 and out_ready=0: out_data, out_row, out_col and out_last are held bit-stable; out_valid never drops.
  - out_valid does not depend combinationally on out_ready. out_data is driven from registers or a counter-indexed mux of the capture register; no combinational path from result_in.
  - Handshake with out_last=1: next cycle out_valid=0, busy=0, done=1 for exactly one cycle, FSM to IDLE.
- busy = (state==STREAM).
- load while busy=1 is ignored, including in the cycle of the final handshake. The capture register is not disturbed.
- load in the done cycle is accepted normally, so back-to-back matrices have a one-cycle bubble.
- result_in is sampled only at the accepted load edge; later changes have no effect on the stream.
- No arithmetic: data passes through unchanged, unsigned, full ACC_WIDTH.

Optional Feature:
- Macro: MATMUL_STREAM_OVERRUN_EN.
- Defined:
  - overrun sets to 1 on any edge where load=1 and busy=1.
  - It stays set until reset; the dropped load is still ignored.
- Undefined: overrun is tied to 0 and no overrun logic is built.

Test Plan:
- Reset hold, then release:
  - All outputs 0.
  - out_valid stays 0 for 10 cycles with load=0.
- load with elements 0x0001..0x0009 (e0=0x0001 in MSBs), out_ready=1 continuously:
  - out_valid from cycle T+1 for 9 consecutive cycles with data 0x0001..0x0009.
  - (row,col) = (0,0),(0,1),(0,2),(1,0),...,(2,2).
  - out_last only on 0x0009; done=1 at T+10; busy=0 at T+10.
- Same load, out_ready toggling 1,0,0,1,...:
  - No element lost or duplicated.
  - Values held stable during stalls; total of 9 handshakes.
- Second load with data 0xFFFF.. pulsed mid-stream:
  - Stream still emits the original 9 values.
  - overrun=1 with MATMUL_STREAM_OVERRUN_EN defined, 0 without.
- load asserted again in the done cycle with elements 0xA000..0xA008:
  - Second stream begins the next cycle with 0xA000, row=0, col=0.
- reset asserted after the 4th handshake:
  - Next cycle out_valid=0, busy=0, done=0.
  - No further elements emitted after reset is released.

Source files
------------

// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer: captures a packed ROW_LEN x COL_LEN result matrix on
// load and drains it row-major, one element per valid/ready handshake.
// Optional build macro: MATMUL_STREAM_OVERRUN_EN (sticky flag for loads
// dropped while busy; when undefined, overrun is tied low).
module matmul_result_streamer #(
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned ROW_LEN   = 3,
  parameter int unsigned COL_LEN   = 3,
  parameter int unsigned NUM_ELEMS = ROW_LEN * COL_LEN,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic [NUM_ELEMS*ACC_WIDTH-1:0] result_in,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_data,
  output logic [IDX_W-1:0]               out_row,
  output logic [IDX_W-1:0]               out_col,
  output logic                           out_last,
  output logic                           done,
  output logic                           overrun
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROW_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COL_LEN - 1);

  logic [0:0]                     state_q, state_d;
  logic [NUM_ELEMS*ACC_WIDTH-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               row_q, row_d;
  logic [IDX_W-1:0]               col_q, col_d;
  logic                           done_q, done_d;
  logic                           handshake;
  logic                           at_last;
  logic [ACC_WIDTH-1:0]           elem_sel;

  assign busy      = (state_q == S_STREAM);
  assign out_valid = busy;
  assign handshake = out_valid & out_ready;
  assign at_last   = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign out_last  = out_valid & at_last;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign done      = done_q;
  assign out_data  = out_valid ? elem_sel : '0;

  // Select the current element from the capture register; element 0 sits in the MSBs.
  always_comb begin
    elem_sel = '0;
    for (int unsigned e = 0; e < NUM_ELEMS; e++) begin
      if (idx_q == IDX_W'(e)) begin
        elem_sel = cap_q[(NUM_ELEMS - e) * ACC_WIDTH - 1 -: ACC_WIDTH];
      end
    end
  end

  // Next-state logic: capture on load in IDLE, advance on each handshake in STREAM.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          cap_d   = result_in;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (at_last) begin
            // Indices return to zero so the idle outputs read as all-zero.
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, capture and index registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

`ifdef MATMUL_STREAM_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky flag for a load that arrives while a matrix is still draining.
  always_comb begin
    overrun_d = overrun_q | (load & busy);
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Directed-plus-random bench for matmul_result_streamer: each matrix is kept
// as a plain element list and the expected stream is that list in order.
module tb_matmul_result_streamer;

  localparam int unsigned W  = 16;
  localparam int unsigned R  = 3;
  localparam int unsigned C  = 3;
  localparam int unsigned N  = R * C;
  localparam int unsigned IW = 4;

  logic              clk;
  logic              reset;
  logic              load;
  logic [N*W-1:0]    result_in;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IW-1:0]     out_row;
  logic [IW-1:0]     out_col;
  logic              out_last;
  logic              done;
  logic              overrun;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_e [N];
  logic         exp_ovr;

  matmul_result_streamer #(
    .ACC_WIDTH(W),
    .ROW_LEN  (R),
    .COL_LEN  (C),
    .IDX_W    (IW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .result_in(result_in),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_col  (out_col),
    .out_last (out_last),
    .done     (done),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Build the packed vector by shifting elements in order, so element 0 ends in the MSBs.
  function automatic logic [N*W-1:0] pack_exp();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v = (v << W) | (N*W)'(exp_e[i]);
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v = (v << W) | (N*W)'($urandom_range(0, 65535));
    return v;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) exp_e[i] = W'($urandom_range(0, 65535));
  endtask

  task automatic do_load();
    result_in = pack_exp();
    load = 1'b1;
    step();
    load = 1'b0;
    result_in = rand_vec();
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
  // inject: pulse a conflicting load mid-stream and in the final handshake cycle.
  task automatic drain(input int mode, input bit inject);
    int k;
    int cyc;
    bit rdy;
    k = 0;
    cyc = 0;
    while (k < N && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (inject && (cyc == 3 || (k == N - 1 && rdy))) begin
        load = 1'b1;
        result_in = '1;
      end else begin
        load = 1'b0;
      end
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data",  32'(out_data),  32'(exp_e[k]));
      chk("stream_row",   32'(out_row),   32'(k / C));
      chk("stream_col",   32'(out_col),   32'(k % C));
      chk("stream_last",  32'(out_last),  32'(k == N - 1));
      chk("stream_busy",  32'(busy),      32'd1);
      chk("stream_done",  32'(done),      32'd0);
      if (rdy) k++;
      step();
      cyc++;
    end
    load = 1'b0;
    if (k < N) chk("drain_budget", 32'(k), 32'(N));
    chk("done_pulse",  32'(done),      32'd1);
    chk("done_valid",  32'(out_valid), 32'd0);
    chk("done_busy",   32'(busy),      32'd0);
    chk("done_last",   32'(out_last),  32'd0);
  endtask

  initial begin
`ifdef MATMUL_STREAM_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    reset = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    result_in = rand_vec();

    // Reset hold: every output zero.
    repeat (3) step();
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    32'(out_data),  32'd0);
    chk("rst_row",     32'(out_row),   32'd0);
    chk("rst_col",     32'(out_col),   32'd0);
    chk("rst_last",    32'(out_last),  32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);

    // Released with no load: stays idle.
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      step();
    end

    // Sequential values 1..9 with continuous ready.
    for (int i = 0; i < N; i++) exp_e[i] = W'(i + 1);
    do_load();
    drain(0, 1'b0);
    step();
    chk("done_once", 32'(done), 32'd0);
    chk("ovr_clean", 32'(overrun), 32'd0);

    // Same values with ready stalls.
    do_load();
    drain(1, 1'b0);
    step();

    // Random values, random ready, conflicting loads while busy.
    fill_random();
    do_load();
    drain(2, 1'b1);
    step();
    chk("post_ign_valid", 32'(out_valid), 32'd0);
    chk("overrun_flag",   32'(overrun),   32'(exp_ovr));

    // Back-to-back: next load accepted in the done cycle.
    fill_random();
    do_load();
    drain(0, 1'b0);
    for (int i = 0; i < N; i++) exp_e[i] = W'(16'hA000 + i);
    do_load();
    drain(1, 1'b0);
    step();
    chk("b2b_done_once", 32'(done), 32'd0);

    // Reset after the fourth handshake abandons the matrix.
    fill_random();
    do_load();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pre_rst_data", 32'(out_data), 32'(exp_e[i]));
      step();
    end
    reset = 1'b0;
    step();
    chk("mid_rst_valid",   32'(out_valid), 32'd0);
    chk("mid_rst_busy",    32'(busy),      32'd0);
    chk("mid_rst_done",    32'(done),      32'd0);
    chk("mid_rst_overrun", 32'(overrun),   32'd0);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
